// File: rtl/leaf_out_arbiter_if.sv
// Requester-side and leaf-side stream signals of the leaf output arbiter.
// master drives the requests and the leaf ack; slave is the arbiter itself.
interface leaf_out_arbiter_if #(
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_REQ      = 4
);
    logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req;
    logic [NUM_REQ-1:0]              vld_req;
    logic [NUM_REQ-1:0]              ack_req;
    logic [PAYLOAD_BITS-1:0]         dout;
    logic                            vld_out;
    logic                            ack_out;

    // Handshake: a word moves on every clock edge where valid and ack are both
    // high. Valid never waits for ack; ack_req may be high while vld_req is low.
    modport master (
        output din_req, vld_req, ack_out,
        input  ack_req, dout, vld_out
    );

    modport slave (
        input  din_req, vld_req, ack_out,
        output ack_req, dout, vld_out
    );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter sharing one leaf_interface input lane among NUM_REQ kernel output
// streams, grants capped at BURST_LEN words. Define ARB_STATS_EN for grant/word counters.
module leaf_out_arbiter #(
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_REQ      = 4,
    parameter int REQ_BITS     = 2,
    parameter int BURST_LEN    = 16
) (
    input  logic                clk,
    input  logic                reset,
    leaf_out_arbiter_if.slave   bus,
    output logic [REQ_BITS-1:0] grant_id,
    output logic                busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         stat_grants,
    output logic [31:0]         stat_words
`endif
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [REQ_BITS-1:0] r_gnt;
    logic [REQ_BITS-1:0] r_last;
    logic [7:0]          r_cnt;

    logic [REQ_BITS-1:0] w_pick;
    logic                w_any;
    logic                w_vld_gnt;
    logic                w_xfer;
    logic                w_burst_end;
    logic                w_exit;

    // Walk downwards so the nearest set index after r_last is the one that sticks.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.vld_req[(int'(r_last) + k) % NUM_REQ]) begin
                w_any  = 1'b1;
                w_pick = REQ_BITS'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_vld_gnt   = bus.vld_req[r_gnt];
        w_xfer      = (r_state == S_GRANT) && w_vld_gnt && bus.ack_out;
        w_burst_end = w_xfer && (r_cnt == 8'(BURST_LEN - 1));
        w_exit      = (r_state == S_GRANT) && (!w_vld_gnt || w_burst_end);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_exit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt  <= '0;
            r_last <= REQ_BITS'(NUM_REQ - 1);
            r_cnt  <= '0;
        end else if ((r_state == S_IDLE) && w_any) begin
            r_gnt <= w_pick;
            r_cnt <= '0;
        end else if (w_exit) begin
            r_last <= r_gnt;
            r_cnt  <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Pure pass-through of the granted requester; ack_req depends only on state and ack_out.
    always_comb begin
        bus.dout    = '0;
        bus.vld_out = 1'b0;
        bus.ack_req = '0;
        grant_id    = '0;
        busy        = 1'b0;
        if (r_state == S_GRANT) begin
            bus.dout           = bus.din_req[int'(r_gnt)*PAYLOAD_BITS +: PAYLOAD_BITS];
            bus.vld_out        = w_vld_gnt;
            bus.ack_req[r_gnt] = bus.ack_out;
            grant_id           = r_gnt;
            busy               = 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_grants;
    logic [31:0] r_stat_words;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_grants <= '0;
            r_stat_words  <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any) begin
                r_stat_grants <= r_stat_grants + 32'd1;
            end
            if (w_xfer) begin
                r_stat_words <= r_stat_words + 32'd1;
            end
        end
    end

    assign stat_grants = r_stat_grants;
    assign stat_words  = r_stat_words;
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: reset/arbitration vector table, directed burst,
// back-pressure and reset corner sequences, then randomized traffic vs a reference model.
module tb_leaf_out_arbiter;
    localparam int PB = 32;
    localparam int NR = 4;
    localparam int RB = 2;
    localparam int BL = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    leaf_out_arbiter_if #(.PAYLOAD_BITS(PB), .NUM_REQ(NR)) bus ();
    logic [RB-1:0] grant_id;
    logic          busy;
`ifdef ARB_STATS_EN
    logic [31:0]   stat_grants;
    logic [31:0]   stat_words;
`endif

    leaf_out_arbiter #(
        .PAYLOAD_BITS(PB), .NUM_REQ(NR), .REQ_BITS(RB), .BURST_LEN(BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_words (stat_words)
`endif
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (owner / words taken / last served) ----------------
    int          m_owner;
    int          m_last;
    int          m_taken;
    logic [31:0] m_grants;
    logic [31:0] m_words;

    task automatic model_reset();
        m_owner  = -1;
        m_last   = NR - 1;
        m_taken  = 0;
        m_grants = '0;
        m_words  = '0;
    endtask

    // ---------------- requester drivers ----------------
    int          want[NR];      // 0 off, 1 offer whenever data, 2 random valid
    int          ack_mode;      // 0 low, 1 high, 2 random
    int          req_left[NR];
    int          req_seq[NR];
    logic        req_pend[NR];
    logic        req_vld[NR];
    logic [31:0] req_word[NR];
    logic [31:0] exp_q[NR][$];

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            bus.din_req[i*PB +: PB] = req_word[i];
            bus.vld_req[i]          = req_vld[i];
        end
        case (ack_mode)
            0:       bus.ack_out = 1'b0;
            1:       bus.ack_out = 1'b1;
            default: bus.ack_out = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic req_update(input logic [NR-1:0] acked);
        for (int i = 0; i < NR; i++) begin
            if (req_vld[i] && acked[i]) req_pend[i] = 1'b0;
            if (!req_pend[i] && req_left[i] > 0 && want[i] != 0) begin
                req_word[i] = {8'(i), 24'(req_seq[i])};
                req_seq[i]++;
                req_left[i]--;
                req_pend[i] = 1'b1;
                exp_q[i].push_back(req_word[i]);
            end
            case (want[i])
                0:       req_vld[i] = 1'b0;
                1:       req_vld[i] = req_pend[i];
                default: req_vld[i] = req_pend[i] && ($urandom_range(0, 4) != 0);
            endcase
        end
        drive_inputs();
    endtask

    // Values sampled in the last step, for the directed sequences.
    logic          s_busy;
    logic [RB-1:0] s_gid;
    logic          s_xfer;
    logic [NR-1:0] s_ack_req;
    logic [PB-1:0] s_dout;

    // One clock: compare against the model at negedge, advance model, update drivers after the edge.
    task automatic step();
        logic [NR-1:0] acked;
        logic          e_busy;
        logic          e_vld;
        logic [NR-1:0] e_ack;
        logic [RB-1:0] e_gid;
        logic [PB-1:0] e_dout;
        int            id;
        logic          v;
        @(negedge clk);
        e_busy = (m_owner >= 0);
        e_gid  = e_busy ? RB'(m_owner) : '0;
        e_vld  = e_busy ? bus.vld_req[m_owner] : 1'b0;
        e_ack  = e_busy ? (NR'(bus.ack_out) << m_owner) : '0;
        e_dout = e_busy ? bus.din_req[m_owner*PB +: PB] : '0;
        check("busy", busy, e_busy);
        check("grant_id", grant_id, e_gid);
        check("vld_out", bus.vld_out, e_vld);
        check("ack_req", bus.ack_req, e_ack);
        check("dout", bus.dout, e_dout);

        s_busy    = busy;
        s_gid     = grant_id;
        s_xfer    = bus.vld_out && bus.ack_out;
        s_ack_req = bus.ack_req;
        s_dout    = bus.dout;

        // Scoreboard: each transferred word must be the oldest outstanding word of its requester.
        if (s_xfer) begin
            id = int'(bus.dout[31:24]);
            if (id < NR && exp_q[id].size() > 0) begin
                check("sb_data", bus.dout, exp_q[id].pop_front());
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got %0h expected no transfer", bus.dout);
            end
        end
        acked = bus.ack_req & bus.vld_req;

        if (!reset) begin
            if (m_owner < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    if (m_owner < 0 && bus.vld_req[(m_last + k) % NR]) begin
                        m_owner = (m_last + k) % NR;
                        m_taken = 0;
                        m_grants++;
                    end
                end
            end else begin
                v = bus.vld_req[m_owner];
                if (v && bus.ack_out) begin
                    m_taken++;
                    m_words++;
                end
                if (!v || m_taken == BL) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end

        @(posedge clk);
        #1;
        req_update(acked);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < NR; i++) want[i] = 0;
        req_update('0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        int pending;
        ack_mode = 1;
        for (int i = 0; i < NR; i++) want[i] = 1;
        req_update('0);
        pending = 0;
        for (int c = 0; c < 3000; c++) begin
            pending = 0;
            for (int i = 0; i < NR; i++) pending += exp_q[i].size() + req_left[i];
            if (pending == 0) break;
            step();
        end
        check("drain_pending", pending, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NR-1:0] vld;
        logic          ack;
        logic          e_vld;
        logic [NR-1:0] e_ack;
        logic [RB-1:0] e_gid;
        logic          e_busy;
    } vec_t;

    vec_t          tbl[11];
    logic [PB-1:0] tdin[NR];

    initial begin
        int first;
        int words;
        int done_at;
        int prev_busy;
        int idle_run;
        int cur_w;
        int gseq[$];
        int wq[$];
        int gap[$];
        int bub[$];
        int exp_order[5];
        logic [PB-1:0] e_dout;

        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1};
        tbl[3]  = '{4'b0110, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[4]  = '{4'b0010, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[5]  = '{4'b0011, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[6]  = '{4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1};
        tbl[7]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1};
        tbl[8]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0};
        for (int i = 0; i < NR; i++) tdin[i] = 32'hA5A0_0000 + 32'(i * 17 + 3);

        reset = 1'b1;
        model_reset();
        ack_mode = 0;
        for (int i = 0; i < NR; i++) begin
            want[i]     = 0;
            req_left[i] = 0;
            req_seq[i]  = 0;
            req_pend[i] = 1'b0;
            req_vld[i]  = 1'b0;
            req_word[i] = '0;
        end
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Table: fixed data per requester, direct vld/ack stimulus.
        for (int r = 0; r < 11; r++) begin
            for (int i = 0; i < NR; i++) bus.din_req[i*PB +: PB] = tdin[i];
            bus.vld_req = tbl[r].vld;
            bus.ack_out = tbl[r].ack;
            @(negedge clk);
            e_dout = tbl[r].e_busy ? tdin[tbl[r].e_gid] : '0;
            check($sformatf("tbl%0d_vld_out", r), bus.vld_out, tbl[r].e_vld);
            check($sformatf("tbl%0d_ack_req", r), bus.ack_req, tbl[r].e_ack);
            check($sformatf("tbl%0d_grant_id", r), grant_id, tbl[r].e_gid);
            check($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            check($sformatf("tbl%0d_dout", r), bus.dout, e_dout);
            @(posedge clk);
            #1;
        end

        // Idle after reset for 20 cycles.
        do_reset();
        repeat (20) step();

        // Lone requester, 40 words: bubbles after words 16 and 32, 42 cycles overall.
        want[2] = 1;
        req_left[2] = 40;
        ack_mode = 1;
        req_update('0);
        first = -1;
        words = 0;
        done_at = -1;
        for (int c = 0; c < 200 && done_at < 0; c++) begin
            step();
            if (s_busy && first < 0) first = c;
            if (s_xfer) words++;
            if (first >= 0 && !s_busy) bub.push_back(words);
            if (words == 40) done_at = c;
        end
        check("lone_total_cycles", done_at - first + 1, 42);
        check("lone_bubbles", bub.size(), 2);
        if (bub.size() == 2) begin
            check("lone_bubble0", bub[0], 16);
            check("lone_bubble1", bub[1], 32);
        end
        drain();

        // All four valid: grants 0,1,2,3,0, 16 words each, one idle cycle between.
        do_reset();
        req_left[0] = 32;
        for (int i = 1; i < NR; i++) req_left[i] = 16;
        for (int i = 0; i < NR; i++) want[i] = 1;
        ack_mode = 1;
        req_update('0);
        prev_busy = 0;
        idle_run = 0;
        cur_w = 0;
        for (int c = 0; c < 400 && wq.size() < 5; c++) begin
            step();
            if (s_busy && prev_busy == 0) begin
                gseq.push_back(int'(s_gid));
                gap.push_back(idle_run);
                cur_w = 0;
            end
            if (s_busy && s_xfer) cur_w++;
            if (!s_busy) begin
                if (prev_busy != 0) wq.push_back(cur_w);
                idle_run++;
            end else begin
                idle_run = 0;
            end
            prev_busy = int'(s_busy);
        end
        exp_order = '{0, 1, 2, 3, 0};
        check("rr_grant_count", gseq.size(), 5);
        for (int k = 0; k < gseq.size() && k < 5; k++) check($sformatf("rr_order%0d", k), gseq[k], exp_order[k]);
        for (int k = 0; k < wq.size(); k++) check($sformatf("rr_words%0d", k), wq[k], BL);
        for (int k = 1; k < gap.size(); k++) check($sformatf("rr_gap%0d", k), gap[k], 1);
        drain();

        // Back-pressure on requester 1 for 10 cycles.
        do_reset();
        want[1] = 1;
        req_left[1] = 8;
        ack_mode = 1;
        req_update('0);
        words = 0;
        for (int c = 0; c < 50 && words < 3; c++) begin
            step();
            if (s_xfer) words++;
        end
        ack_mode = 0;
        drive_inputs();
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_grant_id", s_gid, 1);
            check("bp_ack_req", s_ack_req, 0);
            check("bp_dout", s_dout, req_word[1]);
        end
        ack_mode = 1;
        drive_inputs();
        for (int c = 0; c < 100 && (req_left[1] > 0 || exp_q[1].size() > 0); c++) begin
            step();
            if (s_xfer) words++;
        end
        check("bp_total_words", words, 8);

        // Requester 3 goes idle after 5 words while requester 0 waits.
        do_reset();
        want[3] = 1;
        req_left[3] = 5;
        ack_mode = 1;
        req_update('0);
        for (int c = 0; c < 20 && !s_busy; c++) step();
        check("drop_first_grant", s_gid, 3);
        want[0] = 1;
        req_left[0] = 3;
        req_update('0);
        first = -1;
        done_at = -1;
        words = 1;  // the first grant cycle above already moved word 1
        for (int c = 0; c < 50 && first < 0; c++) begin
            step();
            if (s_xfer && s_gid == 3) begin
                words++;
                done_at = c;
            end
            if (s_busy && s_gid == 0) first = c;
        end
        check("drop_words", words, 5);
        check("drop_regrant_delay", first - done_at, 3);
        drain();

        // Reset in the middle of a burst of requester 2 (word 7 in flight).
        do_reset();
        want[2] = 1;
        req_left[2] = 16;
        ack_mode = 1;
        req_update('0);
        words = 0;
        for (int c = 0; c < 50 && words < 6; c++) begin
            step();
            if (s_xfer) words++;
        end
        reset = 1'b1;
        model_reset();
        want[1] = 1;
        req_left[1] = 4;
        want[3] = 1;
        req_left[3] = 4;
        req_update('0);
        #1;
        check("rst_vld_out", bus.vld_out, 1'b0);
        check("rst_ack_req", bus.ack_req, 0);
        check("rst_busy", busy, 1'b0);
`ifdef ARB_STATS_EN
        check("rst_stat_grants", stat_grants, 0);
        check("rst_stat_words", stat_words, 0);
`endif
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 20 && !s_busy; c++) step();
        check("rst_next_grant", s_gid, 1);
        drain();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            want[i] = 2;
            req_left[i] = 60;
        end
        ack_mode = 2;
        req_update('0);
        repeat (800) step();
        drain();
`ifdef ARB_STATS_EN
        check("stat_grants", stat_grants, m_grants);
        check("stat_words", stat_words, m_words);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
